// File: rtl/half_adder_pkg.sv
// Shared definitions for the half_adder_reg slice.
//   DEFAULT_WIDTH : default lane count
//   ha_f(a,b)     : single-lane half-adder function, returns {cout,sum}
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;

  function automatic logic [1:0] ha_f(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_reg_if.sv
// Operand/result bundle for half_adder_reg.
//   in_valid, a, b       : operand side (driven by master)
//   sum, cout, out_valid : result side (driven by slave)
interface half_adder_reg_if
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cout;
  logic             out_valid;

  modport master (output in_valid, a, b, input sum, cout, out_valid);
  modport slave  (input in_valid, a, b, output sum, cout, out_valid);

endinterface

// File: rtl/half_adder_bit.sv
// Combinational 1-bit half-adder cell.
//   a, b : operand bits
//   sum  : a ^ b
//   cout : a & b
module half_adder_bit
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign {cout, sum} = ha_f(a, b);

endmodule

// File: rtl/half_adder_reg.sv
// Lane-parallel half adder with an optional output register.
//   clk, rst : rising-edge clock, async active-high reset (REG_OUT=1 only)
//   bus      : slave side of half_adder_reg_if
//              in:  in_valid, a[WIDTH], b[WIDTH]
//              out: sum[WIDTH], cout[WIDTH], out_valid
// Lanes are independent; no carry travels between them.
module half_adder_reg
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  half_adder_reg_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] cout_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_bit u_cell (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .sum  (sum_c[i]),
      .cout (cout_c[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;
    logic             vld_pipe;

    // Data only loads on in_valid, so garbage on a/b while idle never
    // reaches the held result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q    <= '0;
        cout_q   <= '0;
        vld_pipe <= 1'b0;
      end else begin
        vld_pipe <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q  <= sum_c;
          cout_q <= cout_c;
        end
      end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = vld_pipe;
  end else begin : g_comb
    // Pure bypass: clock and reset have no role here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign bus.sum       = sum_c;
    assign bus.cout      = cout_c;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_half_adder_reg.sv
module tb_half_adder_reg;
  import half_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  half_adder_reg_if #(.WIDTH(1)) if1 ();
  half_adder_reg_if #(.WIDTH(8)) if8 ();
  half_adder_reg_if #(.WIDTH(1)) if0 ();

  half_adder_reg #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  half_adder_reg #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  half_adder_reg #(.WIDTH(1), .REG_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each lane is a 1-bit + 1-bit addition; low bit is sum, high bit is carry.
  typedef struct { logic [7:0] s; logic [7:0] c; } exp_t;
  exp_t q8[$];

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    for (int i = 0; i < 8; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      r.s[i] = (t % 2) != 0;
      r.c[i] = (t / 2) != 0;
    end
    return r;
  endfunction

  // Monitor / scoreboard for the 8-lane registered instance.
  exp_t last8 = '{8'h00, 8'h00};
  exp_t e8;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst8_sum", if8.sum, 32'h0);
      chk("rst8_cout", if8.cout, 32'h0);
      chk("rst8_ovld", if8.out_valid, 32'h0);
      last8 = '{8'h00, 8'h00};
    end else if (if8.out_valid) begin
      if (q8.size() == 0) begin
        chk("sb8_unexpected_valid", 32'h1, 32'h0);
      end else begin
        e8 = q8.pop_front();
        chk("sb8_sum", if8.sum, e8.s);
        chk("sb8_cout", if8.cout, e8.c);
        last8 = e8;
      end
    end else begin
      chk("hold8_sum", if8.sum, last8.s);
      chk("hold8_cout", if8.cout, last8.c);
    end
    chk("inv8", if8.sum & if8.cout, 32'h0);
  end

  task automatic drive1(input logic a, input logic b, input logic v);
    @(posedge clk);
    #1;
    if1.in_valid = v;
    if1.a = a;
    if1.b = b;
  endtask

  logic [3:0] es = 4'b0110;  // sum for ab = 00,01,10,11 (indexed by {a,b})
  logic [3:0] ec = 4'b1000;  // cout for the same index

  initial begin
    if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00;
    if0.in_valid = 1'b0; if0.a = 1'b0; if0.b = 1'b0;

    // Reset state of the single-lane instance while rst is held.
    #3;
    chk("rst1_sum", if1.sum, 32'h0);
    chk("rst1_cout", if1.cout, 32'h0);
    chk("rst1_ovld", if1.out_valid, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Truth table, one pair per cycle.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      drive1(kk[1], kk[0], 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tt_sum_%0d", k), if1.sum, es[kk]);
      chk($sformatf("tt_cout_%0d", k), if1.cout, ec[kk]);
      chk($sformatf("tt_ovld_%0d", k), if1.out_valid, 32'h1);
    end

    // Hold while idle, including garbage on a.
    drive1(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("load11_cout", if1.cout, 32'h1);
    chk("load11_sum", if1.sum, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive1((k == 2) ? 1'bx : 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_cout_%0d", k), if1.cout, 32'h1);
      chk($sformatf("hold_sum_%0d", k), if1.sum, 32'h0);
      chk($sformatf("hold_ovld_%0d", k), if1.out_valid, 32'h0);
    end

    // Asynchronous reset while sum=1.
    drive1(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_sum", if1.sum, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", if1.sum, 32'h0);
    chk("arst_cout", if1.cout, 32'h0);
    chk("arst_ovld", if1.out_valid, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_sum", if1.sum, 32'h0);
    chk("rst_held_ovld", if1.out_valid, 32'h0);
    q8.delete();
    #1 rst = 1'b0;
    #1;
    chk("rel_sum", if1.sum, 32'h0);
    chk("rel_ovld", if1.out_valid, 32'h0);
    @(posedge clk);
    #1;
    chk("first_cap_sum", if1.sum, 32'h1);
    chk("first_cap_ovld", if1.out_valid, 32'h1);
    if1.in_valid = 1'b0;

    // Combinational variant: follows inputs with no clock edge involved.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      if0.in_valid = kk[2];
      if0.a = kk[1];
      if0.b = kk[0];
      #1;
      chk($sformatf("comb_sum_%0d", k), if0.sum, es[kk[1:0]]);
      chk($sformatf("comb_cout_%0d", k), if0.cout, ec[kk[1:0]]);
      chk($sformatf("comb_ovld_%0d", k), if0.out_valid, kk[2]);
    end

    // 8-lane directed vector.
    @(posedge clk);
    #1;
    if8.in_valid = 1'b1; if8.a = 8'hF0; if8.b = 8'hCC;
    q8.push_back(model(8'hF0, 8'hCC));
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
    @(negedge clk);
    chk("w8_sum", if8.sum, 32'h3C);
    chk("w8_cout", if8.cout, 32'hC0);

    // Random stream, mostly back-to-back with occasional bubbles.
    for (int n = 0; n < 1000; n++) begin
      logic       v;
      logic [7:0] a;
      logic [7:0] b;
      v = ($urandom_range(0, 4) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      if8.in_valid = v; if8.a = a; if8.b = b;
      if (v) q8.push_back(model(a, b));
    end
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb8_drained", q8.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
